// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 arrow-key receiver: scancodes, direction
// encodings, frame FSM states and the arrow lookup.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Direction code doubles as the bit index into keys {right,left,down,up}.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    FR_IDLE   = 2'd0,
    FR_DATA   = 2'd1,
    FR_PARITY = 2'd2,
    FR_STOP   = 2'd3
  } frame_st_e;

  typedef struct packed {
    logic hit;
    dir_e dir;
  } arrow_t;

  function automatic arrow_t arrow_decode(input logic [7:0] sc);
    arrow_t r;
    r.hit = 1'b1;
    r.dir = DIR_UP;
    case (sc)
      SC_UP:    r.dir = DIR_UP;
      SC_DOWN:  r.dir = DIR_DOWN;
      SC_LEFT:  r.dir = DIR_LEFT;
      SC_RIGHT: r.dir = DIR_RIGHT;
      default:  r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame receiver: sync, glitch filter,
// start/data/parity/stop deframing with an inter-edge timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int TIMEOUT_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0]        FMAX = FW'(FILTER_LEN - 1);
  localparam logic [TIMEOUT_W-1:0] TMAX = TIMEOUT_W'(TIMEOUT_CYC - 1);

  logic [1:0]    clk_sy, dat_sy;
  logic          clk_s, dat_s;
  logic          clk_f;
  logic [FW-1:0] fcnt;
  logic          smp;

  assign clk_s = clk_sy[1];
  assign dat_s = dat_sy[1];

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sy <= 2'b11;
      dat_sy <= 2'b11;
      clk_f  <= 1'b1;
      fcnt   <= '0;
    end else begin
      clk_sy <= {clk_sy[0], ps2_clk};
      dat_sy <= {dat_sy[0], ps2_data};
      if (clk_s == clk_f) begin
        fcnt <= '0;
      end else if (fcnt == FMAX) begin
        clk_f <= clk_s;
        fcnt  <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  // Sample event: the cycle in which the filtered clock is about to fall.
  assign smp = clk_f & ~clk_s & (fcnt == FMAX);

  frame_st_e            state_q, state_d;
  logic [2:0]           bcnt_q, bcnt_d;
  logic [7:0]           sh_q, sh_d;
  logic                 par_q, par_d;
  logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
  logic                 ok, err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FR_IDLE;
      bcnt_q     <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      tcnt_q     <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      tcnt_q     <= tcnt_d;
      code_valid <= ok;
      frame_err  <= err;
      if (ok) code <= sh_q;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    ok      = 1'b0;
    err     = 1'b0;
    tcnt_d  = (smp || state_q == FR_IDLE) ? '0 : tcnt_q + TIMEOUT_W'(1);

    if (smp) begin
      case (state_q)
        FR_IDLE: begin
          if (!dat_s) begin
            state_d = FR_DATA;
            bcnt_d  = '0;
          end else begin
            err = 1'b1;
          end
        end
        FR_DATA: begin
          sh_d   = {dat_s, sh_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = FR_PARITY;
        end
        FR_PARITY: begin
          par_d   = dat_s;
          state_d = FR_STOP;
        end
        FR_STOP: begin
          state_d = FR_IDLE;
          if (dat_s && (^{sh_q, par_q})) ok = 1'b1;
          else                           err = 1'b1;
        end
        default: state_d = FR_IDLE;
      endcase
    end else if (state_q != FR_IDLE && tcnt_q == TMAX) begin
      state_d = FR_IDLE;
      err     = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_dir_rx.sv
// Pac-Man player input: PS/2 frame receiver plus extended arrow-key
// make/break decoder producing held-key flags and a direction strobe.
module ps2_dir_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int TIMEOUT_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err,
  output logic [3:0] keys,
  output logic [1:0] dir,
  output logic       dir_valid
);

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TIMEOUT_W  (TIMEOUT_W)
  ) u_frame (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (code),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  logic   e0, f0;
  arrow_t arw;

  assign arw = arrow_decode(code);

  // A break releases its key but leaves dir on the last make.
  always_ff @(posedge clk) begin
    if (rst) begin
      keys      <= '0;
      dir       <= DIR_UP;
      dir_valid <= 1'b0;
      e0        <= 1'b0;
      f0        <= 1'b0;
    end else begin
      dir_valid <= 1'b0;
      if (frame_err) begin
        e0 <= 1'b0;
        f0 <= 1'b0;
      end else if (code_valid) begin
        case (code)
          SC_EXT:   e0 <= 1'b1;
          SC_BREAK: f0 <= 1'b1;
          default: begin
            e0 <= 1'b0;
            f0 <= 1'b0;
            if (e0 && arw.hit) begin
              if (!f0) begin
                keys[arw.dir] <= 1'b1;
                dir           <= arw.dir;
                dir_valid     <= 1'b1;
              end else begin
                keys[arw.dir] <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_dir_rx.sv
// Directed bench for ps2_dir_rx: table of frames with expected key state,
// plus timeout, glitch and mid-frame reset sequences.
module tb_ps2_dir_rx;

  localparam int FL   = 8;
  localparam int TO   = 1000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_valid, frame_err, dir_valid;
  logic [3:0] keys;
  logic [1:0] dir;

  ps2_dir_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .code_valid(code_valid), .frame_err(frame_err),
    .keys(keys), .dir(dir), .dir_valid(dir_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cv = 0, n_err = 0, n_dv = 0, err_cyc = 0, last_fall = 0;
  logic [7:0] last_code = '0;
  always @(negedge clk) begin
    if (code_valid) begin n_cv++; last_code = code; end
    if (frame_err) begin n_err++; err_cyc = cyc; end
    if (dir_valid) n_dv++;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input bit badpar, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, ~(^b) ^ badpar, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      tick(HALF);
      ps2_clk = 1'b0;
      last_fall = cyc;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit badpar);
    send_bits(b, badpar, 11);
    tick(30);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         bad;
    bit         cv;
    bit         er;
    bit         dv;
    logic [3:0] keys;
    logic [1:0] dir;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [7:0] b, input bit bad, input bit cv, input bit er,
                     input bit dv, input logic [3:0] k, input logic [1:0] d);
    vec_t v;
    v.b = b; v.bad = bad; v.cv = cv; v.er = er; v.dv = dv; v.keys = k; v.dir = d;
    tv.push_back(v);
  endtask

  task automatic snap_check(input string tag, input int cv0, input int er0, input int dv0,
                            input int dcv, input int der, input int ddv);
    chk({tag, "_cv"},  n_cv - cv0,  dcv);
    chk({tag, "_err"}, n_err - er0, der);
    chk({tag, "_dv"},  n_dv - dv0,  ddv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cv0, er0, dv0, d;

    // b, badpar, cv, err, dv, keys, dir
    add(8'hE0, 0, 1, 0, 0, 4'h0, 2'd0);
    add(8'h75, 0, 1, 0, 1, 4'h1, 2'd0);
    add(8'hE0, 0, 1, 0, 0, 4'h1, 2'd0);
    add(8'hF0, 0, 1, 0, 0, 4'h1, 2'd0);
    add(8'h75, 0, 1, 0, 0, 4'h0, 2'd0);
    add(8'hE0, 0, 1, 0, 0, 4'h0, 2'd0);
    add(8'h6B, 0, 1, 0, 1, 4'h4, 2'd2);
    add(8'hE0, 0, 1, 0, 0, 4'h4, 2'd2);
    add(8'h72, 0, 1, 0, 1, 4'h6, 2'd1);
    add(8'hE0, 0, 1, 0, 0, 4'h6, 2'd1);
    add(8'hF0, 0, 1, 0, 0, 4'h6, 2'd1);
    add(8'h72, 0, 1, 0, 0, 4'h4, 2'd1);
    add(8'h1C, 1, 0, 1, 0, 4'h4, 2'd1);
    add(8'hE0, 0, 1, 0, 0, 4'h4, 2'd1);
    add(8'h74, 0, 1, 0, 1, 4'hC, 2'd3);
    add(8'hE0, 0, 1, 0, 0, 4'hC, 2'd3);
    add(8'h74, 0, 1, 0, 1, 4'hC, 2'd3);
    add(8'hE0, 0, 1, 0, 0, 4'hC, 2'd3);
    add(8'h1C, 0, 1, 0, 0, 4'hC, 2'd3);
    add(8'h75, 0, 1, 0, 0, 4'hC, 2'd3);
    add(8'hE0, 0, 1, 0, 0, 4'hC, 2'd3);
    add(8'h75, 1, 0, 1, 0, 4'hC, 2'd3);
    add(8'h75, 0, 1, 0, 0, 4'hC, 2'd3);

    // Reset state
    tick(4);
    chk("rst_keys", keys, 0);
    chk("rst_dir", dir, 0);
    chk("rst_code", code, 0);
    chk("rst_pulses", {code_valid, frame_err, dir_valid}, 0);
    rst = 1'b0;
    tick(10);

    foreach (tv[i]) begin
      cv0 = n_cv; er0 = n_err; dv0 = n_dv;
      send_frame(tv[i].b, tv[i].bad);
      snap_check($sformatf("v%0d", i), cv0, er0, dv0, tv[i].cv, tv[i].er, tv[i].dv);
      if (tv[i].cv) chk($sformatf("v%0d_code", i), last_code, tv[i].b);
      chk($sformatf("v%0d_keys", i), keys, tv[i].keys);
      chk($sformatf("v%0d_dir", i), dir, tv[i].dir);
    end

    // Partial frame followed by a dead clock: exactly one timeout error.
    cv0 = n_cv; er0 = n_err; dv0 = n_dv;
    send_bits(8'h75, 0, 5);
    d = last_fall;
    tick(TO + 10);
    snap_check("timeout", cv0, er0, dv0, 0, 1, 0);
    d = err_cyc - d;
    chk("timeout_lat", (d >= TO && d <= TO + FL + 8), 1);
    cv0 = n_cv; er0 = n_err; dv0 = n_dv;
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h6B, 0);
    snap_check("post_to", cv0, er0, dv0, 3, 0, 0);
    chk("post_to_code", last_code, 8'h6B);
    chk("post_to_keys", keys, 4'h8);
    chk("post_to_dir", dir, 2'd3);

    // Short low glitch on the clock must be filtered out.
    cv0 = n_cv; er0 = n_err; dv0 = n_dv;
    tick(5);
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(40);
    snap_check("glitch", cv0, er0, dv0, 0, 0, 0);

    // Reset mid-frame: outputs clear, partial frame dropped silently.
    send_bits(8'hE0, 0, 5);
    rst = 1'b1;
    tick(1);
    chk("mrst_keys", keys, 0);
    chk("mrst_dir", dir, 0);
    chk("mrst_code", code, 0);
    chk("mrst_pulses", {code_valid, frame_err, dir_valid}, 0);
    rst = 1'b0;
    cv0 = n_cv; er0 = n_err; dv0 = n_dv;
    tick(TO + 50);
    snap_check("mrst_idle", cv0, er0, dv0, 0, 0, 0);
    send_frame(8'hE0, 0);
    send_frame(8'h72, 0);
    snap_check("mrst_after", cv0, er0, dv0, 2, 0, 1);
    chk("mrst_after_code", last_code, 8'h72);
    chk("mrst_after_keys", keys, 4'h2);
    chk("mrst_after_dir", dir, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
